// File: rtl/sap1_controller.sv
// SAP-1 control sequencer.
//
// A six-state one-hot ring counter (T1..T6) advances on every falling edge of
// CLK, so the control word decoded from it is settled half a cycle before the
// rising edge on which the datapath registers load.
//
// Ports:
//   CLK     in   1  system clock; ring/halt update on the falling edge
//   CLR     in   1  synchronous active-low clear (sampled on the falling edge);
//                   also blanks CON combinationally while low
//   OPCODE  in   4  instruction-register upper nibble
//   CON     out 12  control word {CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}
//   T       out  6  one-hot ring state, T[0]=T1 .. T[5]=T6
//   HLT     out  1  sticky halt request, cleared only by CLR
//
// state | meaning
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR
// T4    | execute 1 (LDA/ADD/SUB address, OUT transfer, HLT detect)
// T5    | execute 2
// T6    | execute 3
// HALT  | T frozen at T4 with HLT=1, all control bits off

module sap1_controller (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  OPCODE,
  output logic [11:0] CON,
  output logic [5:0]  T,
  output logic        HLT
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [5:0] t_next;
  logic       hlt_next;

  // State register: clear has priority over advance and halt.
  always_ff @(negedge CLK) begin
    if (!CLR) begin
      T   <= T1;
      HLT <= 1'b0;
    end else begin
      T   <= t_next;
      HLT <= hlt_next;
    end
  end

  // Next state. Any non-one-hot encoding falls to the default and restarts at T1.
  always_comb begin
    t_next   = T1;
    hlt_next = HLT;
    if (HLT) begin
      t_next = T4;
    end else begin
      case (T)
        T1: t_next = T2;
        T2: t_next = T3;
        T3: t_next = T4;
        T4: begin
          if (OPCODE == OP_HLT) begin
            t_next   = T4;
            hlt_next = 1'b1;
          end else begin
            t_next = T5;
          end
        end
        T5: t_next = T6;
        T6: t_next = T1;
        default: t_next = T1;
      endcase
    end
  end

  // Control word. OPCODE only matters in T4..T6 because IR loads at the end
  // of T3; HLT in T4 falls into the NOP default, which gives the blank word.
  always_comb begin
    CON = 12'h000;
    if (CLR && !HLT) begin
      case (T)
        T1: CON = EP | LM;
        T2: CON = CP;
        T3: CON = CE | LI;
        T4: begin
          case (OPCODE)
            OP_LDA, OP_ADD, OP_SUB: CON = LM | EI;
            OP_OUT:                 CON = EA | LO;
            default:                CON = 12'h000;
          endcase
        end
        T5: begin
          case (OPCODE)
            OP_LDA:         CON = CE | LA;
            OP_ADD, OP_SUB: CON = CE | LB;
            default:        CON = 12'h000;
          endcase
        end
        T6: begin
          case (OPCODE)
            OP_ADD:  CON = EU | LA;
            OP_SUB:  CON = SU | EU | LA;
            default: CON = 12'h000;
          endcase
        end
        default: CON = 12'h000;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Testbench for sap1_controller: a constant vector table for fetch/decode,
// then model-driven sequences for halt, clear-from-halt, clear mid-instruction
// and a back-to-back program trace.

module tb_sap1_controller;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [3:0]  OPCODE;
  logic [11:0] CON;
  logic [5:0]  T;
  logic        HLT;

  int n_checks  = 0;
  int n_fail    = 0;
  int hlt_rises = 0;

  always #5 CLK = ~CLK;

  sap1_controller dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .OPCODE (OPCODE),
    .CON    (CON),
    .T      (T),
    .HLT    (HLT)
  );

  always @(posedge HLT) hlt_rises++;

  typedef struct {
    logic        clr;
    logic [3:0]  op;
    logic [11:0] con;
    logic [5:0]  t;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int   m_step;
  logic m_hlt;

  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change just after the falling (state) edge; outputs are sampled
  // just after the following rising edge.
  task automatic drive(vec_t v, string tag);
    vec_t e;
    @(negedge CLK);
    #1;
    CLR    = v.clr;
    OPCODE = v.op;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 12'h001, 12'h000);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".CON"}, CON, e.con);
      check({tag, ".T"}, {6'h00, T}, {6'h00, e.t});
      check({tag, ".HLT"}, {11'h000, HLT}, {11'h000, e.hlt});
    end
  endtask

  task automatic add_vec(logic clr, logic [3:0] op, logic [11:0] con, logic [5:0] t, logic hlt);
    vec_t v;
    v.clr = clr; v.op = op; v.con = con; v.t = t; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  task automatic add_instr(logic [3:0] op, logic [11:0] w4, logic [11:0] w5, logic [11:0] w6);
    add_vec(1'b1, op, 12'h600, 6'b000001, 1'b0);
    add_vec(1'b1, op, 12'h800, 6'b000010, 1'b0);
    add_vec(1'b1, op, 12'h180, 6'b000100, 1'b0);
    add_vec(1'b1, op, w4,      6'b001000, 1'b0);
    add_vec(1'b1, op, w5,      6'b010000, 1'b0);
    add_vec(1'b1, op, w6,      6'b100000, 1'b0);
  endtask

  // Instruction-level reference: microstep index 0..5 and halt flag.
  function automatic logic [11:0] ref_word(int step, logic [3:0] op, logic hlt, logic clr);
    logic [11:0] w;
    w = 12'h000;
    if (clr && !hlt) begin
      case (step)
        0: w = 12'h600;
        1: w = 12'h800;
        2: w = 12'h180;
        3: w = (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h240 :
               (op == 4'hE) ? 12'h011 : 12'h000;
        4: w = (op == 4'h0) ? 12'h120 :
               (op == 4'h1 || op == 4'h2) ? 12'h102 : 12'h000;
        5: w = (op == 4'h1) ? 12'h024 : (op == 4'h2) ? 12'h02C : 12'h000;
        default: w = 12'h000;
      endcase
    end
    return w;
  endfunction

  task automatic model_cycle(logic clr, logic [3:0] op, string tag);
    vec_t e;
    e.clr = clr;
    e.op  = op;
    e.con = ref_word(m_step, op, m_hlt, clr);
    e.t   = 6'(1 << m_step);
    e.hlt = m_hlt;
    drive(e, tag);
    if (!clr) begin
      m_step = 0;
      m_hlt  = 1'b0;
    end else if (!m_hlt) begin
      if (m_step == 3 && op == 4'hF) m_hlt = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
  endtask

  initial begin
    CLR    = 1'b0;
    OPCODE = 4'h5;

    // Reset and release, fetch with an unused opcode, then each instruction.
    add_vec(1'b0, 4'h5, 12'h000, 6'b000001, 1'b0);
    add_instr(4'h5, 12'h000, 12'h000, 12'h000);
    add_instr(4'h0, 12'h240, 12'h120, 12'h000);
    add_instr(4'h1, 12'h240, 12'h102, 12'h024);
    add_instr(4'h2, 12'h240, 12'h102, 12'h02C);
    add_instr(4'hE, 12'h011, 12'h000, 12'h000);
    add_instr(4'h3, 12'h000, 12'h000, 12'h000);
    // OPCODE wiggling during fetch must not disturb the fetch words.
    add_vec(1'b1, 4'hF, 12'h600, 6'b000001, 1'b0);
    add_vec(1'b1, 4'hE, 12'h800, 6'b000010, 1'b0);
    add_vec(1'b1, 4'h0, 12'h180, 6'b000100, 1'b0);
    add_vec(1'b1, 4'h1, 12'h240, 6'b001000, 1'b0);
    add_vec(1'b1, 4'h1, 12'h102, 6'b010000, 1'b0);
    add_vec(1'b1, 4'h1, 12'h024, 6'b100000, 1'b0);
    add_vec(1'b1, 4'h5, 12'h600, 6'b000001, 1'b0);

    @(negedge CLK);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], $sformatf("vec%0d", i));
    end

    // Resynchronise with the model through a clear.
    @(negedge CLK);
    #1;
    CLR = 1'b0;
    @(negedge CLK);
    m_step = 0;
    m_hlt  = 1'b0;
    hlt_rises = 0;

    // Program trace: LDA, ADD, SUB, OUT, HLT, then ten halted cycles.
    for (int i = 0; i < 6; i++) model_cycle(1'b1, 4'h0, $sformatf("lda%0d", i));
    for (int i = 0; i < 6; i++) model_cycle(1'b1, 4'h1, $sformatf("add%0d", i));
    for (int i = 0; i < 6; i++) model_cycle(1'b1, 4'h2, $sformatf("sub%0d", i));
    for (int i = 0; i < 6; i++) model_cycle(1'b1, 4'hE, $sformatf("out%0d", i));
    for (int i = 0; i < 4; i++) model_cycle(1'b1, 4'hF, $sformatf("hlt%0d", i));
    for (int i = 0; i < 10; i++) model_cycle(1'b1, 4'(i), $sformatf("halted%0d", i));
    check("halt.T_frozen", {6'h00, T}, 12'h008);
    check("halt.CON_blank", CON, 12'h000);
    check("halt.rise_count", 12'(hlt_rises), 12'd1);

    // Clear from the halted state.
    model_cycle(1'b0, 4'hF, "clr_halt0");
    model_cycle(1'b0, 4'h0, "clr_halt1");
    model_cycle(1'b1, 4'h0, "clr_halt_rel");
    check("clr_halt.HLT", {11'h000, HLT}, 12'h000);

    // Clear asserted during T5 of an ADD.
    model_cycle(1'b1, 4'h1, "mid_t2");
    model_cycle(1'b1, 4'h1, "mid_t3");
    model_cycle(1'b1, 4'h1, "mid_t4");
    model_cycle(1'b0, 4'h1, "mid_t5_clr");
    model_cycle(1'b0, 4'h1, "mid_after_clr");
    check("mid.T1", {6'h00, T}, 12'h001);
    model_cycle(1'b1, 4'h1, "mid_rel_t1");
    model_cycle(1'b1, 4'h1, "mid_rel_t2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
